// File: rtl/fp_mult_pkg.sv
// Shared constants and stage-1 payload for the FP multiplier back end.
package fp_mult_pkg;

  localparam int PKG_EXP_W  = 10;
  localparam int PKG_FRAC_W = 23;
  localparam int EXPF_W     = 8;
  localparam int BIAS       = 127;
  localparam int EXP_MAX    = 2 * BIAS + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Normalised product waiting for rounding
  typedef struct packed {
    logic                  sign;
    logic [PKG_EXP_W-1:0]  exp;     // biased, two's complement
    logic [PKG_FRAC_W:0]   keep;    // 24-bit significand incl. hidden bit
    logic                  guard;
    logic                  sticky;
    logic                  zero;
    logic                  inf;
    logic                  nan;
  } s1_pay_t;

endpackage

// File: rtl/fp_mult_round_pack_if.sv
// Input beat + output result handshake bundle for fp_mult_round_pack.
interface fp_mult_round_pack_if #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 48
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              in_zero;
  logic              in_inf;
  logic              in_nan;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_overflow;
  logic              out_underflow;
  logic              out_inexact;
  logic              out_invalid;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_inexact, out_invalid
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_inexact, out_invalid
  );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised 24-bit significand.
// FP_ROUND_SUBNORMAL_EN: denormalise tiny results before rounding; the
// returned exponent field is then 0, or 1 when rounding reaches min normal.
module fp_round_rne
  import fp_mult_pkg::*;
#(
  parameter int EXP_W  = PKG_EXP_W,
  parameter int FRAC_W = PKG_FRAC_W
) (
  input  logic [FRAC_W:0]          keep_i,
  input  logic                     guard_i,
  input  logic                     sticky_i,
  input  logic signed [EXP_W-1:0]  exp_i,
  output logic [FRAC_W-1:0]        frac_o,
  output logic signed [EXP_W-1:0]  exp_o,
  output logic                     inexact_o,
  output logic                     tiny_o
);

  logic [FRAC_W:0] k;
  logic            g, s;
  logic            roundup, cfrac, carry;

`ifdef FP_ROUND_SUBNORMAL_EN
  localparam int SH_W = $clog2(FRAC_W + 3);
  logic signed [EXP_W-1:0] dist;
  logic [SH_W-1:0]         sh;
  logic [FRAC_W+1:0]       ext, lost;
`endif

  // Optional denormalise, then RNE increment; the increment is done on the
  // fraction only so a carry out of all-ones is detected against the hidden bit
  always_comb begin
    tiny_o = exp_i[EXP_W-1] | (exp_i == '0);
    k = keep_i;
    g = guard_i;
    s = sticky_i;
`ifdef FP_ROUND_SUBNORMAL_EN
    dist = $signed(EXP_W'(1)) - exp_i;
    sh   = (dist > $signed(EXP_W'(FRAC_W + 2))) ? SH_W'(FRAC_W + 2) : dist[SH_W-1:0];
    ext  = {keep_i, guard_i};
    lost = ~({(FRAC_W+2){1'b1}} << sh);
    if (tiny_o) begin
      {k, g} = ext >> sh;
      s      = sticky_i | (|(ext & lost));
    end
`endif
    roundup         = g & (s | k[0]);
    {cfrac, frac_o} = {1'b0, k[FRAC_W-1:0]} + {{FRAC_W{1'b0}}, roundup};
    carry           = k[FRAC_W] & cfrac;
    inexact_o       = g | s;
    exp_o           = carry ? exp_i + EXP_W'(1) : exp_i;
`ifdef FP_ROUND_SUBNORMAL_EN
    if (tiny_o) begin
      exp_o    = '0;
      exp_o[0] = k[FRAC_W] | cfrac;
    end
`endif
  end

endmodule

// File: rtl/fp_mult_round_pack.sv
// FP multiplier back end: normalise (stage 1), round + pack (stage 2),
// valid/ready on both sides. FP_ROUND_SUBNORMAL_EN selects gradual underflow
// instead of flush-to-zero.
module fp_mult_round_pack
  import fp_mult_pkg::*;
#(
  parameter int EXP_W  = PKG_EXP_W,
  parameter int FRAC_W = PKG_FRAC_W
) (
  input  logic clk,
  input  logic reset,
  fp_mult_round_pack_if.slave bus
);

  localparam int MANT_W = 2 * FRAC_W + 2;

  logic adv1, adv2;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  s1_pay_t s1_q, s1_d;

  logic [31:0] res_q, res_d, pk_res;
  logic        ovf_q, ovf_d, pk_ovf;
  logic        unf_q, unf_d, pk_unf;
  logic        inx_q, inx_d, pk_inx;
  logic        inv_q, inv_d, pk_inv;

  logic [FRAC_W-1:0]        rnd_frac;
  logic signed [EXP_W-1:0]  rnd_exp;
  logic                     rnd_inexact, rnd_tiny;

  // A stage moves when it is empty or the stage after it moves
  assign adv2         = !s2_valid_q | bus.out_ready;
  assign adv1         = !s1_valid_q | adv2;
  assign bus.in_ready = adv1;

  // Stage 1: pick the 24 significand bits below the leading one
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
    if (adv1) begin
      s1_d.sign = bus.in_sign;
      s1_d.zero = bus.in_zero;
      s1_d.inf  = bus.in_inf;
      s1_d.nan  = bus.in_nan;
      if (bus.in_mant[MANT_W-1]) begin
        s1_d.exp    = bus.in_exp + EXP_W'(1);
        s1_d.keep   = bus.in_mant[MANT_W-1 -: FRAC_W+1];
        s1_d.guard  = bus.in_mant[MANT_W-FRAC_W-2];
        s1_d.sticky = |bus.in_mant[MANT_W-FRAC_W-3:0];
      end else begin
        s1_d.exp    = bus.in_exp;
        s1_d.keep   = bus.in_mant[MANT_W-2 -: FRAC_W+1];
        s1_d.guard  = bus.in_mant[MANT_W-FRAC_W-3];
        s1_d.sticky = |bus.in_mant[MANT_W-FRAC_W-4:0];
      end
    end
  end

  fp_round_rne #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_rne (
    .keep_i    (s1_q.keep),
    .guard_i   (s1_q.guard),
    .sticky_i  (s1_q.sticky),
    .exp_i     ($signed(s1_q.exp)),
    .frac_o    (rnd_frac),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact),
    .tiny_o    (rnd_tiny)
  );

  // Pack: specials first, then underflow, overflow, ordinary result
  always_comb begin
    pk_res = {s1_q.sign, rnd_exp[EXPF_W-1:0], rnd_frac};
    pk_ovf = 1'b0;
    pk_unf = 1'b0;
    pk_inx = rnd_inexact;
    pk_inv = 1'b0;
    if (s1_q.nan || (s1_q.inf && s1_q.zero)) begin
      pk_res = QNAN;
      pk_inx = 1'b0;
      pk_inv = 1'b1;
    end else if (s1_q.inf) begin
      pk_res = {s1_q.sign, {EXPF_W{1'b1}}, {FRAC_W{1'b0}}};
      pk_inx = 1'b0;
    end else if (s1_q.zero) begin
      pk_res = {s1_q.sign, 31'b0};
      pk_inx = 1'b0;
    end else if (rnd_tiny) begin
`ifdef FP_ROUND_SUBNORMAL_EN
      pk_unf = rnd_inexact;
`else
      pk_res = {s1_q.sign, 31'b0};
      pk_unf = 1'b1;
      pk_inx = 1'b1;
`endif
    end else if (rnd_exp >= $signed(EXP_W'(EXP_MAX))) begin
      pk_res = {s1_q.sign, {EXPF_W{1'b1}}, {FRAC_W{1'b0}}};
      pk_ovf = 1'b1;
      pk_inx = 1'b1;
    end
  end

  // Stage 2: capture a packed result only when a real beat moves in
  always_comb begin
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    res_d = res_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    inx_d = inx_q;
    inv_d = inv_q;
    if (adv2 && s1_valid_q) begin
      res_d = pk_res;
      ovf_d = pk_ovf;
      unf_d = pk_unf;
      inx_d = pk_inx;
      inv_d = pk_inv;
    end
  end

  // Pipeline registers; reset drops any in-flight beat at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inx_q      <= inx_d;
      inv_q      <= inv_d;
    end
  end

  assign bus.out_valid     = s2_valid_q;
  assign bus.out_result    = res_q;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = unf_q;
  assign bus.out_inexact   = inx_q;
  assign bus.out_invalid   = inv_q;

endmodule

// File: tb/tb_fp_mult_round_pack.sv
// Directed bench for fp_mult_round_pack: arithmetic vectors, specials,
// backpressure ordering and asynchronous reset.
module tb_fp_mult_round_pack;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [31:0] got[$];
  logic [31:0] bp_x[3];
  logic        pend;
  int          cyc;

  fp_mult_round_pack_if #(.EXP_W(10), .MANT_W(48)) bus ();

  fp_mult_round_pack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
  endtask

  // {overflow, underflow, inexact, invalid}
  function automatic logic [3:0] flags();
    return {bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_invalid};
  endfunction

  // zin = {zero, inf, nan}
  task automatic put(input logic s, input logic [9:0] e, input logic [47:0] m, input logic [2:0] zin);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    {bus.in_zero, bus.in_inf, bus.in_nan} = zin;
  endtask

  task automatic run1(input string tag, input logic s, input logic [9:0] e, input logic [47:0] m,
                      input logic [2:0] zin, input logic [31:0] xres, input logic [3:0] xflg);
    int c;
    @(negedge clk);
    put(s, e, m, zin);
    @(negedge clk);
    bus.in_valid = 1'b0;
    c = 1;
    while (!bus.out_valid && c < 8) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_lat"}, 32'(c), 32'd2);
    chk({tag, "_res"}, bus.out_result, xres);
    chk({tag, "_flg"}, 32'(flags()), 32'(xflg));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_exp   = '0;
    bus.in_mant  = '0;
    bus.in_zero  = 1'b0;
    bus.in_inf   = 1'b0;
    bus.in_nan   = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_res", bus.out_result, 32'h0);
    chk("rst_flg", 32'(flags()), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);

    // arithmetic and specials
    run1("mul15",    1'b0, 10'd127, 48'h9000_0000_0000, 3'b000, 32'h4010_0000, 4'b0000);
    run1("tie_even", 1'b0, 10'd127, 48'h4000_0040_0000, 3'b000, 32'h3F80_0000, 4'b0010);
    run1("tie_odd",  1'b0, 10'd127, 48'h4000_00C0_0000, 3'b000, 32'h3F80_0002, 4'b0010);
    run1("sticky",   1'b0, 10'd127, 48'h4000_0000_0001, 3'b000, 32'h3F80_0000, 4'b0010);
    run1("carry",    1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 3'b000, 32'h4000_0000, 4'b0010);
    run1("max_exp",  1'b0, 10'd253, 48'h8000_0000_0000, 3'b000, 32'h7F00_0000, 4'b0000);
    run1("ovf",      1'b1, 10'd254, 48'h8000_0000_0000, 3'b000, 32'hFF80_0000, 4'b1010);
    run1("ovf_rnd",  1'b0, 10'd254, 48'h7FFF_FFFF_FFFF, 3'b000, 32'h7F80_0000, 4'b1010);
    run1("inf_zero", 1'b0, 10'd127, 48'h9000_0000_0000, 3'b110, 32'h7FC0_0000, 4'b0001);
    run1("zero_neg", 1'b1, 10'd127, 48'h9000_0000_0000, 3'b100, 32'h8000_0000, 4'b0000);
    run1("inf",      1'b0, 10'd127, 48'h9000_0000_0000, 3'b010, 32'h7F80_0000, 4'b0000);
    run1("nan",      1'b1, 10'd127, 48'h9000_0000_0000, 3'b001, 32'h7FC0_0000, 4'b0001);
    run1("min_norm", 1'b0, 10'd1,   48'h4000_0000_0000, 3'b000, 32'h0080_0000, 4'b0000);
`ifdef FP_ROUND_SUBNORMAL_EN
    run1("tiny",     1'b0, 10'd0,   48'h4000_0000_0000, 3'b000, 32'h0040_0000, 4'b0000);
`else
    run1("tiny",     1'b0, 10'd0,   48'h4000_0000_0000, 3'b000, 32'h0000_0000, 4'b0110);
`endif

    // backpressure: two beats fill the pipe, the third is refused
    bp_x[0] = 32'h4010_0000;
    bp_x[1] = 32'h3F80_0002;
    bp_x[2] = 32'h4000_0000;
    @(negedge clk);
    bus.out_ready = 1'b0;
    put(1'b0, 10'd127, 48'h9000_0000_0000, 3'b000);
    #1 chk("bp_rdy_a", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    put(1'b0, 10'd127, 48'h4000_00C0_0000, 3'b000);
    chk("bp_rdy_b", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    put(1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 3'b000);
    chk("bp_rdy_c", 32'(bus.in_ready), 32'd0);
    chk("bp_vld", 32'(bus.out_valid), 32'd1);
    chk("bp_hold0", bus.out_result, bp_x[0]);
    @(negedge clk);
    chk("bp_rdy_c2", 32'(bus.in_ready), 32'd0);
    chk("bp_hold1", bus.out_result, bp_x[0]);
    bus.out_ready = 1'b1;
    #1;
    pend = 1'b0;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (pend) bus.in_valid = 1'b0;
      pend = bus.in_valid & bus.in_ready;
      if (bus.out_valid) got.push_back(bus.out_result);
    end
    bus.in_valid = 1'b0;
    chk("bp_cnt", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_ord%0d", k), (got.size() > k) ? got[k] : 32'hDEAD_DEAD, bp_x[k]);

    // reset while stalled
    @(negedge clk);
    bus.out_ready = 1'b0;
    put(1'b1, 10'd127, 48'h9000_0000_0000, 3'b000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_res", bus.out_result, 32'hC010_0000);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_async_res", bus.out_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("post_rst_vld", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
